// File: rtl/count_seq_pkg.sv
// Shared types for the count_seq burst sequencer: FSM state encoding and default width.
package count_seq_pkg;

  localparam int N_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/count_seq_tchk.sv
// QFB toggle checker: counts level changes inside the run window and flags a
// mismatch against the requested cycle count when the burst completes.
module count_seq_tchk
  import count_seq_pkg::*;
#(
  parameter int N_W = N_W_DEF
) (
  input  logic           CK,
  input  logic           RSTB,
  input  logic           clr,
  input  logic           win,
  input  logic           eval,
  input  logic           qfb,
  input  logic [N_W-1:0] ncyc,
  output logic           err
);

  logic           qfb_p0;
  logic [N_W-1:0] tcnt;
  logic           chg;
  logic [N_W:0]   total;

  assign chg   = win && (qfb != qfb_p0);
  // The DRAIN-cycle change is folded in combinationally so ERR is valid in FIN.
  assign total = {1'b0, tcnt} + {{N_W{1'b0}}, chg};

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      qfb_p0 <= 1'b0;
      tcnt   <= '0;
      err    <= 1'b0;
    end else begin
      qfb_p0 <= qfb;
      if (clr) begin
        tcnt <= '0;
        err  <= 1'b0;
      end else begin
        if (chg && (tcnt != '1)) tcnt <= tcnt + 1'b1;
        if (eval) err <= (total != {1'b0, ncyc});
      end
    end
  end

endmodule

// File: rtl/count_seq.sv
// Burst sequencer for a toggle counter: IDLE -> ARM -> RUN x NCYC -> DRAIN -> FIN.
// Define COUNT_SEQ_TOGGLE_CHECK_EN to build in the QFB toggle checker (ERR).
module count_seq
  import count_seq_pkg::*;
#(
  parameter int N_W = N_W_DEF
) (
  input  logic           CK,
  input  logic           RSTB,
  input  logic           START,
  input  logic           ABORT,
  input  logic [N_W-1:0] NCYC,
  input  logic           QFB,
  output logic           EN,
  output logic           BUSY,
  output logic           DONE,
  output logic [N_W-1:0] CNT,
  output logic           ERR
);

  state_e         state, state_nxt;
  logic [N_W-1:0] ncyc_q;
  logic [N_W-1:0] rem_q;
  logic           accept;

  assign accept = (state == IDLE) && START && !ABORT;
  assign BUSY   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    if (ABORT && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = (NCYC == '0) ? FIN : ARM;
        ARM:     state_nxt = RUN;
        RUN:     if (rem_q <= 1) state_nxt = DRAIN;
        DRAIN:   state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      state <= IDLE;
      EN    <= 1'b0;
      DONE  <= 1'b0;
      CNT   <= '0;
    end else begin
      state <= state_nxt;
      EN    <= (state_nxt == RUN);
      DONE  <= (state_nxt == FIN);
      // A RUN cycle cut short by ABORT still had EN high, so it is counted.
      if (accept) CNT <= '0;
      else if ((state == RUN) && (CNT != ncyc_q)) CNT <= CNT + 1'b1;
    end
  end

  // Down-counter leaves RUN at 1, so it never wraps even for an all-ones NCYC.
  always_ff @(posedge CK) begin
    if (accept) begin
      ncyc_q <= NCYC;
      rem_q  <= NCYC;
    end else if (state == RUN) begin
      rem_q  <= rem_q - 1'b1;
    end
  end

`ifdef COUNT_SEQ_TOGGLE_CHECK_EN
  logic win;
  logic eval;

  // CNT is still zero in the first RUN cycle, which the window excludes.
  assign win  = ((state == RUN) && (CNT != '0)) || (state == DRAIN);
  assign eval = (state == DRAIN) && !ABORT;

  count_seq_tchk #(.N_W(N_W)) u_tchk (
    .CK   (CK),
    .RSTB (RSTB),
    .clr  (accept),
    .win  (win),
    .eval (eval),
    .qfb  (QFB),
    .ncyc (ncyc_q),
    .err  (ERR)
  );
`else
  logic unused_qfb;

  assign unused_qfb = QFB;
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq.sv
// Directed + randomized bench for count_seq (N_W=8 and N_W=4 instances side by side).
module tb_count_seq;

`ifdef COUNT_SEQ_TOGGLE_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       CK, RSTB, START, ABORT;
  logic [7:0] NCYC8, CNT8;
  logic [3:0] NCYC4, CNT4;
  logic       Q8, Q4, stuck;
  logic       EN8, BUSY8, DONE8, ERR8;
  logic       EN4, BUSY4, DONE4, ERR4;

  int n_cmp = 0;
  int n_bad = 0;

  count_seq #(.N_W(8)) dut8 (
    .CK(CK), .RSTB(RSTB), .START(START), .ABORT(ABORT), .NCYC(NCYC8), .QFB(Q8),
    .EN(EN8), .BUSY(BUSY8), .DONE(DONE8), .CNT(CNT8), .ERR(ERR8)
  );

  count_seq #(.N_W(4)) dut4 (
    .CK(CK), .RSTB(RSTB), .START(START), .ABORT(ABORT), .NCYC(NCYC4), .QFB(Q4),
    .EN(EN4), .BUSY(BUSY4), .DONE(DONE4), .CNT(CNT4), .ERR(ERR4)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural toggle flip-flops fed by EN; "stuck" pins Q at 0.
  always @(posedge CK) begin
    if (!RSTB || stuck) begin
      Q8 <= 1'b0;
      Q4 <= 1'b0;
    end else begin
      if (EN8) Q8 <= ~Q8;
      if (EN4) Q4 <= ~Q4;
    end
  end

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // n: requested cycles, a: cycle carrying ABORT (0 none), r: cycle re-pulsing START (0 none),
  // stk: QFB stuck at 0, c4: also check the 4-bit instance. Cycle 0 carries the accepted START.
  task automatic run_burst(input int n, input int a, input int r, input bit stk, input bit c4);
    int fin, last, kmax, ev;
    bit een, ebusy, edone, eerr;
    fin  = (n == 0) ? 1 : n + 3;
    last = (a > 0) ? a : fin;
    kmax = last + 3;
    @(negedge CK);
    stuck = stk;
    START = 1'b1;
    ABORT = 1'b0;
    NCYC8 = n[7:0];
    NCYC4 = n[3:0];
    for (int k = 1; k <= kmax; k++) begin
      @(negedge CK);
      ev    = (a > 0 && k > a) ? a - 1 : k - 2;
      if (ev < 0) ev = 0;
      if (ev > n) ev = n;
      een   = (n > 0) && (k >= 2) && (k <= n + 1) && (a == 0 || k <= a);
      ebusy = (k <= last);
      edone = (a == 0) && (k == fin);
      eerr  = CHK_ON && stk && (n > 0) && (a == 0) && (k >= fin);
      check("en8",   k, EN8,   een);
      check("busy8", k, BUSY8, ebusy);
      check("done8", k, DONE8, edone);
      check("cnt8",  k, CNT8,  ev);
      check("err8",  k, ERR8,  eerr);
      if (c4) begin
        check("en4",   k, EN4,   een);
        check("busy4", k, BUSY4, ebusy);
        check("done4", k, DONE4, edone);
        check("cnt4",  k, CNT4,  ev);
        check("err4",  k, ERR4,  eerr);
      end
      START = (k == r);
      ABORT = (k == a);
      NCYC8 = 8'($urandom);
      NCYC4 = 4'($urandom);
    end
    START = 1'b0;
    ABORT = 1'b0;
    stuck = 1'b0;
  endtask

  initial begin
    int n, a, r, lst;
    bit stk;
    RSTB  = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    NCYC8 = '0;
    NCYC4 = '0;
    stuck = 1'b0;

    // Reset state
    @(negedge CK);
    check("rst_en8",   0, EN8,   0);
    check("rst_busy8", 0, BUSY8, 0);
    check("rst_done8", 0, DONE8, 0);
    check("rst_cnt8",  0, CNT8,  0);
    check("rst_err8",  0, ERR8,  0);
    check("rst_busy4", 0, BUSY4, 0);
    @(negedge CK);
    RSTB = 1'b1;
    @(negedge CK);
    check("post_rst_busy8", 0, BUSY8, 0);

    run_burst(5, 0, 0, 1'b0, 1'b1);
    run_burst(0, 0, 0, 1'b0, 1'b1);
    run_burst(10, 5, 0, 1'b0, 1'b1);
    run_burst(6, 0, 0, 1'b1, 1'b1);
    run_burst(6, 0, 0, 1'b0, 1'b1);

    // START with ABORT in IDLE: nothing starts, CNT keeps last burst value
    @(negedge CK);
    START = 1'b1;
    ABORT = 1'b1;
    NCYC8 = 8'd7;
    NCYC4 = 4'd7;
    @(negedge CK);
    check("sa_busy8", 1, BUSY8, 0);
    check("sa_en8",   1, EN8,   0);
    check("sa_cnt8",  1, CNT8,  6);
    check("sa_busy4", 1, BUSY4, 0);
    START = 1'b0;
    ABORT = 1'b0;
    @(negedge CK);
    check("sa_busy8_b", 2, BUSY8, 0);

    // Asynchronous reset in the middle of a 20-cycle RUN
    START = 1'b1;
    NCYC8 = 8'd20;
    NCYC4 = 4'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CK);
      START = 1'b0;
    end
    check("mid_en8",  8, EN8,  1);
    check("mid_cnt8", 8, CNT8, 6);
    #1 RSTB = 1'b0;
    #1;
    check("arst_en8",   8, EN8,   0);
    check("arst_busy8", 8, BUSY8, 0);
    check("arst_cnt8",  8, CNT8,  0);
    check("arst_done8", 8, DONE8, 0);
    @(negedge CK);
    check("arst_hold_busy8", 9, BUSY8, 0);
    RSTB = 1'b1;
    run_burst(5, 0, 0, 1'b0, 1'b1);

    // Full-length 4-bit burst with START re-pulsed in RUN, then full-length 8-bit
    run_burst(15, 0, 7, 1'b0, 1'b1);
    run_burst(255, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      n   = int'($urandom_range(0, 15));
      a   = 0;
      r   = 0;
      stk = ($urandom_range(0, 3) == 0);
      if (n > 0 && $urandom_range(0, 2) == 0) a = int'($urandom_range(1, n + 2));
      lst = (a > 0) ? a : ((n == 0) ? 1 : n + 3);
      if (lst >= 2 && $urandom_range(0, 2) == 0) r = int'($urandom_range(2, lst));
      run_burst(n, a, r, stk, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_seq.md
COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 SHALL have parameter N_W, default 8, width of cycle-count target and CNT.
REQ-002 SHALL have port CK  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port RSTB  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request to run one counting burst.
REQ-005 SHALL have port ABORT  input  1  cancel burst in progress.
REQ-006 SHALL have port NCYC  input  N_W  number of enabled CK cycles requested, sampled with START.
REQ-007 SHALL have port QFB  input  1  Q of the toggle counter being sequenced.
REQ-008 SHALL have port EN  output  1  enable to the toggle counter, registered.
REQ-009 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-010 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-011 SHALL have port CNT  output  N_W  EN-high cycles elapsed in current or last burst.
REQ-012 SHALL have port ERR  output  1  toggle-check mismatch flag.

Function
REQ-013 SHALL implement FSM states IDLE, ARM, RUN, DRAIN, FIN.
REQ-014 IDLE: START=1 and ABORT=0 SHALL latch NCYC, clear CNT and ERR, go to ARM; NCYC=0 SHALL go directly to FIN with EN never asserted.
REQ-015 ARM SHALL last exactly one cycle with EN=0, then go to RUN.
REQ-016 RUN SHALL hold EN=1 for exactly NCYC consecutive cycles, increment CNT once per RUN cycle, then go to DRAIN.
REQ-017 DRAIN SHALL last exactly one cycle with EN=0 to let the counter FF settle, then go to FIN.
REQ-018 FIN SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-019 Latency START sample to DONE SHALL be NCYC+3 cycles for NCYC>0, and 1 cycle for NCYC=0.
REQ-020 START outside IDLE SHALL be ignored; no queuing.
REQ-021 ABORT in any non-IDLE state SHALL force IDLE on next edge, EN=0, no DONE pulse, CNT frozen.
REQ-022 START and ABORT together in IDLE: ABORT SHALL win, state stays IDLE.
REQ-023 NCYC = 2^N_W-1 SHALL run full length; internal down-counter SHALL not wrap; CNT saturates at NCYC.
REQ-024 CNT SHALL hold its final value after FIN until the next accepted START.

Reset
REQ-025 RSTB=0 SHALL asynchronously force IDLE, EN=0, BUSY=0, DONE=0, CNT=0, ERR=0.
REQ-026 Reset mid-burst SHALL drop EN within the reset assertion, no DONE.
REQ-027 RSTB deassertion SHALL take effect on the next CK rising edge only.

Configuration
REQ-028 Macro COUNT_SEQ_TOGGLE_CHECK_EN SHALL compile in the QFB toggle checker.
REQ-029 With macro: checker SHALL count QFB level changes sampled from the second RUN cycle through DRAIN inclusive; at FIN ERR SHALL be set if count != latched NCYC, held until next accepted START.
REQ-030 Without macro: ERR SHALL be tied 0 and QFB SHALL be unused.

Structure
REQ-031 Package count_seq_pkg SHALL hold the state enum type and the default N_W constant.
REQ-032 Checker SHALL be sub-module count_seq_tchk, instantiated only under COUNT_SEQ_TOGGLE_CHECK_EN.
REQ-033 FSM, down-counter and CNT register SHALL stay in count_seq.

Verification
REQ-034 NCYC=5, START one cycle -> EN high exactly 5 cycles, DONE at cycle 8 after START, CNT=5, ERR=0 with a model counter on QFB.
REQ-035 NCYC=0, START -> DONE next cycle, EN never high, CNT=0.
REQ-036 NCYC=10, ABORT at 4th RUN cycle -> EN low next edge, no DONE, CNT=4, BUSY=0.
REQ-037 NCYC=6 with QFB held at 0 (macro on) -> ERR=1 with DONE; macro off -> ERR=0.
REQ-038 RSTB low during RUN with NCYC=20 -> EN, BUSY, CNT zero immediately; START after release behaves per REQ-034.
REQ-039 N_W=4, NCYC=15, START re-pulsed during RUN -> single burst, EN high 15 cycles, one DONE.
